// File: rtl/frac_clock_gen.sv
// Multi-channel fractional clock generator built from phase accumulators.
// Each channel adds its increment every enabled cycle; a carry gives one tick.
module frac_clock_gen_ch #(
    parameter int              ACC_BITS = 24,
    parameter logic [ACC_BITS-1:0] INC_RST  = '0
) (
    input  logic                clk_src,
    input  logic                reset_n,
    input  logic                en_i,
    input  logic                sync_i,
    input  logic                wr_en_i,
    input  logic [ACC_BITS-1:0] wr_inc_i,
    output logic                tick_o,
    output logic                clk_out_o,
    output logic                pending_o
);
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [ACC_BITS-1:0] inc_q, inc_d;
    logic [ACC_BITS-1:0] shd_q, shd_d;
    logic                tick_q, tick_d;
    logic                clk_q, clk_d;
    logic                pend_q, pend_d;
    logic [ACC_BITS:0]   sum;
    logic                apply;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d  = acc_q;
        inc_d  = inc_q;
        shd_d  = shd_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        pend_d = pend_q;
        apply  = 1'b0;
        // sync beats carry; a pending increment swaps in on carry, sync or idle
        if (sync_i) begin
            acc_d = '0;
            clk_d = 1'b0;
            apply = pend_q;
        end else if (en_i) begin
            acc_d  = sum[ACC_BITS-1:0];
            tick_d = sum[ACC_BITS];
            clk_d  = sum[ACC_BITS-1];
            apply  = pend_q && sum[ACC_BITS];
        end else begin
            apply = pend_q;
        end
        if (apply) begin
            inc_d  = shd_q;
            pend_d = 1'b0;
        end
        if (wr_en_i) begin
            shd_d  = wr_inc_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_src) begin
        if (!reset_n) begin
            acc_q  <= '0;
            inc_q  <= INC_RST;
            shd_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            shd_q  <= shd_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
            pend_q <= pend_d;
        end
    end

    assign tick_o    = tick_q;
    assign clk_out_o = clk_q;
    assign pending_o = pend_q;
endmodule

module frac_clock_gen #(
    parameter int          CHANNELS    = 2,
    parameter int          ACC_BITS    = 24,
    parameter logic [31:0] INC_DEFAULT = 32'd1921744
) (
    input  logic                clk_src,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] sync,
    input  logic                wr_valid,
    input  logic [2:0]          wr_ch,
    input  logic [ACC_BITS-1:0] wr_inc,
    output logic                wr_ready,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] pending
);
    localparam logic [ACC_BITS-1:0] HALF    = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic [ACC_BITS-1:0] INC_RST =
        (INC_DEFAULT > 32'(HALF)) ? HALF : INC_DEFAULT[ACC_BITS-1:0];

    logic [7:0]          pend_pad;
    logic [ACC_BITS-1:0] wr_clamp;
    logic                wr_accept;
    logic [CHANNELS-1:0] wr_sel;

    // Unused channel slots read as not-pending, so writes to them are always
    // accepted and then dropped because no channel decodes them.
    assign pend_pad  = 8'(pending);
    assign wr_ready  = ~pend_pad[wr_ch];
    assign wr_accept = wr_valid && wr_ready;
    assign wr_clamp  = (wr_inc > HALF) ? HALF : wr_inc;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            wr_sel[i] = wr_accept && (int'(wr_ch) == i);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        frac_clock_gen_ch #(
            .ACC_BITS (ACC_BITS),
            .INC_RST  (INC_RST)
        ) u_ch (
            .clk_src   (clk_src),
            .reset_n   (reset_n),
            .en_i      (en[c]),
            .sync_i    (sync[c]),
            .wr_en_i   (wr_sel[c]),
            .wr_inc_i  (wr_clamp),
            .tick_o    (tick[c]),
            .clk_out_o (clk_out[c]),
            .pending_o (pending[c])
        );
    end
endmodule
